// File: rtl/riscv_pkg.sv
// riscv_pkg: shared memory-op and LSU state types plus load/store/misalign helpers
package riscv_pkg;
  typedef enum logic [3:0] {MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;
  localparam logic [15:0] MEM_OP_IS_LOAD = 16'h003E;
  localparam logic [15:0] MEM_OP_IS_STORE = 16'h01C0;
  function automatic logic is_store(mem_op_t op);
    return MEM_OP_IS_STORE[op];
  endfunction
  function automatic logic is_load(mem_op_t op);
    return MEM_OP_IS_LOAD[op];
  endfunction
  function automatic logic misaligned(mem_op_t op, logic [1:0] off);
    return ((op == LH || op == LHU || op == SH) && off[0]) ||
           ((op == LW || op == SW) && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed byte/halfword from a raw load word and extends it
//   rdata_i raw memory word, off_i byte offset, op_i load op, data_o writeback value
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  mem_op_t         op_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    b = sh[7:0];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = op_i == LB  ? {{(XLEN-8){b[7]}}, b} :
             op_i == LBU ? {{(XLEN-8){1'b0}}, b} :
             op_i == LH  ? {{(XLEN-16){h[15]}}, h} :
             op_i == LHU ? {{(XLEN-16){1'b0}}, h} : rdata_i;
  end
endmodule

// File: rtl/lsu.sv
// lsu: RV32I memory-stage load/store unit with req/gnt/rvalid data port
//   ex_*   execute-stage op, address, store data, rd; lsu_busy stalls upstream
//   dmem_* word-aligned request with byte enables and lane-replicated store data
//   wb_*   one-cycle completed-load pulse; lsu_exc* one-cycle misaligned pulse
module lsu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  mem_op_t           ex_mem_op,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              lsu_busy,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              lsu_exc,
  output logic [XLEN-1:0]   lsu_exc_addr
);
  lsu_state_t state_q, state_d;
  mem_op_t op_q;
  logic [1:0] off_q;
  logic [4:0] rd_q;
  logic accept, misal, go, done;
  logic [3:0] be_d;
  logic [XLEN-1:0] wdata_d, align;
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i(dmem_rdata),
    .off_i  (off_q),
    .op_i   (op_q),
    .data_o (align)
  );
  always_comb begin
    accept = state_q == IDLE && ex_valid && ex_mem_op != MEM_NONE;
    misal = misaligned(ex_mem_op, ex_addr[1:0]);
    go = accept && !misal;
    done = state_q == RESP && dmem_rvalid;
    state_d = state_q == IDLE ? (go ? REQ : IDLE) :
              state_q == REQ  ? (dmem_gnt ? (dmem_we ? IDLE : RESP) : REQ) :
              (dmem_rvalid ? IDLE : RESP);
    wdata_d = ex_mem_op == SB ? {(XLEN/8){ex_wdata[7:0]}} :
              ex_mem_op == SH ? {(XLEN/16){ex_wdata[15:0]}} : ex_wdata;
    be_d = ex_mem_op == SB ? 4'b0001 << ex_addr[1:0] :
           ex_mem_op == SH ? 4'b0011 << ex_addr[1:0] :
           ex_mem_op == SW ? 4'b1111 : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= MEM_NONE;
      off_q <= '0;
      rd_q <= '0;
      lsu_busy <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      lsu_exc <= 1'b0;
      lsu_exc_addr <= '0;
    end else begin
      state_q <= state_d;
      lsu_busy <= state_d != IDLE;
      dmem_req <= state_d == REQ;
      lsu_exc <= accept && misal;
      wb_valid <= done;
      if (accept && misal) lsu_exc_addr <= ex_addr;
      if (go) begin
        op_q <= ex_mem_op;
        off_q <= ex_addr[1:0];
        rd_q <= ex_rd;
        dmem_we <= is_store(ex_mem_op);
        dmem_addr <= {ex_addr[XLEN-1:2], 2'b00};
        dmem_be <= be_d;
        dmem_wdata <= wdata_d;
      end
      if (done) begin
        wb_data <= align;
        wb_rd <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu
module tb_lsu;
  import riscv_pkg::*;
  logic clk, rst, ex_valid, lsu_busy, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic wb_valid, lsu_exc;
  mem_op_t ex_mem_op;
  logic [31:0] ex_addr, ex_wdata, dmem_addr, dmem_wdata, dmem_rdata, wb_data, lsu_exc_addr;
  logic [4:0] ex_rd, wb_rd;
  logic [3:0] dmem_be;
  int total = 0;
  int bad = 0;
  lsu dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .lsu_busy(lsu_busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .lsu_exc(lsu_exc),
    .lsu_exc_addr(lsu_exc_addr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_mem_op = op;
    ex_addr = a;
    ex_wdata = d;
    ex_rd = rd;
  endtask
  task automatic zw_load(input string tag, input mem_op_t op, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    issue(op, a, 32'h0, rd);
    step();
    ex_valid = 1'b0;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, dmem_be, 0);
    chk({tag, "_we"}, dmem_we, 0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk({tag, "_req_drop"}, dmem_req, 0);
    chk({tag, "_busy_resp"}, lsu_busy, 1);
    dmem_rvalid = 1'b1;
    dmem_rdata = rdata;
    step();
    dmem_rvalid = 1'b0;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wbd"}, wb_data, exp);
    chk({tag, "_wbrd"}, wb_rd, rd);
    chk({tag, "_busy_end"}, lsu_busy, 0);
    step();
    chk({tag, "_wbv_pulse"}, wb_valid, 0);
  endtask
  task automatic store(input string tag, input mem_op_t op, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd);
    issue(op, a, d, 5'd0);
    step();
    ex_valid = 1'b0;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_we"}, dmem_we, 1);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, dmem_be, be);
    chk({tag, "_wdata"}, dmem_wdata, wd);
    chk({tag, "_busy"}, lsu_busy, 1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk({tag, "_idle_busy"}, lsu_busy, 0);
    chk({tag, "_idle_req"}, dmem_req, 0);
  endtask
  initial begin
    rst = 1'b1;
    ex_valid = 1'b0;
    ex_mem_op = MEM_NONE;
    ex_addr = 32'h0;
    ex_wdata = 32'h0;
    ex_rd = 5'd0;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
    step();
    step();
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_busy", lsu_busy, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_exc", lsu_exc, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_excaddr", lsu_exc_addr, 0);
    rst = 1'b0;
    step();
    issue(MEM_NONE, 32'h100, 32'h1, 5'd1);
    step();
    ex_valid = 1'b0;
    chk("none_req", dmem_req, 0);
    chk("none_busy", lsu_busy, 0);
    store("sw", SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    store("sb", SB, 32'h41, 32'h000000AB, 4'b0010, 32'hABABABAB);
    store("sh", SH, 32'h42, 32'h1234CAFE, 4'b1100, 32'hCAFECAFE);
    store("sb3", SB, 32'h43, 32'h00000077, 4'b1000, 32'h77777777);
    zw_load("lb", LB, 32'h203, 5'd5, 32'h80FF1234, 32'hFFFFFF80);
    zw_load("lhu", LHU, 32'h202, 5'd6, 32'hBEEF0000, 32'h0000BEEF);
    zw_load("lh", LH, 32'h200, 5'd7, 32'h12348001, 32'hFFFF8001);
    zw_load("lbu", LBU, 32'h201, 5'd8, 32'h0000F200, 32'h000000F2);
    zw_load("lw", LW, 32'h300, 5'd31, 32'h12345678, 32'h12345678);
    issue(LW, 32'h106, 32'h0, 5'd2);
    step();
    ex_valid = 1'b0;
    chk("mis_exc", lsu_exc, 1);
    chk("mis_excaddr", lsu_exc_addr, 32'h106);
    chk("mis_req", dmem_req, 0);
    chk("mis_busy", lsu_busy, 0);
    step();
    chk("mis_exc_pulse", lsu_exc, 0);
    chk("mis_req2", dmem_req, 0);
    issue(SH, 32'h43, 32'h5, 5'd0);
    step();
    ex_valid = 1'b0;
    chk("mis_sh_exc", lsu_exc, 1);
    chk("mis_sh_excaddr", lsu_exc_addr, 32'h43);
    chk("mis_sh_req", dmem_req, 0);
    issue(LW, 32'h400, 32'h0, 5'd9);
    step();
    chk("dly_req1", dmem_req, 1);
    chk("dly_addr1", dmem_addr, 32'h400);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11111111;
    step();
    chk("dly_req2", dmem_req, 1);
    chk("dly_addr2", dmem_addr, 32'h400);
    chk("dly_wbv_ignored", wb_valid, 0);
    step();
    chk("dly_req3", dmem_req, 1);
    chk("dly_be3", dmem_be, 0);
    chk("dly_we3", dmem_we, 0);
    chk("dly_wbv_ignored2", wb_valid, 0);
    dmem_rvalid = 1'b0;
    ex_valid = 1'b0;
    step();
    chk("dly_req4", dmem_req, 1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("dly_req_drop", dmem_req, 0);
    chk("dly_busy5", lsu_busy, 1);
    step();
    chk("dly_busy6", lsu_busy, 1);
    step();
    chk("dly_wbv7", wb_valid, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_rvalid = 1'b0;
    chk("dly_wbv8", wb_valid, 1);
    chk("dly_wbd8", wb_data, 32'hCAFEF00D);
    chk("dly_wbrd8", wb_rd, 9);
    chk("dly_busy8", lsu_busy, 0);
    step();
    issue(LW, 32'h500, 32'h0, 5'd10);
    step();
    ex_valid = 1'b0;
    step();
    step();
    step();
    chk("rr_req4", dmem_req, 1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("rr_busy5", lsu_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_busy6", lsu_busy, 0);
    chk("rr_req6", dmem_req, 0);
    chk("rr_wbv6", wb_valid, 0);
    chk("rr_wbd6", wb_data, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h5A5A5A5A;
    step();
    dmem_rvalid = 1'b0;
    chk("rr_wbv8", wb_valid, 0);
    chk("rr_wbd8", wb_data, 0);
    chk("rr_busy8", lsu_busy, 0);
    step();
    chk("rr_wbv9", wb_valid, 0);
    store("post_rst_sw", SW, 32'h104, 32'h01234567, 4'b1111, 32'h01234567);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
